// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body controller and its helpers.
package snake_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned HEAD_W      = COORD_W + 1;
    localparam int unsigned LEN_W       = 5;
    localparam int unsigned MAX_LEN_DEF = 20;
    localparam int unsigned STEP_DEF    = 10;
    localparam int unsigned X_MIN_DEF   = 150;
    localparam int unsigned X_MAX_DEF   = 779;
    localparam int unsigned Y_MIN_DEF   = 41;
    localparam int unsigned Y_MAX_DEF   = 510;
    localparam int unsigned START_X_DEF = 450;
    localparam int unsigned START_Y_DEF = 281;

    // Coordinate parked in unused slots; never a legal head position.
    localparam logic [COORD_W-1:0] PARK = 10'h3FF;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/snake_hit_detect.sv
// Combinational self-collision check of a candidate head against live segments.
module snake_hit_detect
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic [HEAD_W-1:0]          head_x_i,
    input  logic [HEAD_W-1:0]          head_y_i,
    input  logic [MAX_LEN*COORD_W-1:0] seg_x_i,
    input  logic [MAX_LEN*COORD_W-1:0] seg_y_i,
    input  logic [LEN_W-1:0]           length_i,
    input  logic                       eat_i,
    output logic                       self_hit_c
);

    logic [LEN_W-1:0] limit;

    // The tail slot only counts when eating, since otherwise it moves away.
    always_comb begin
        limit      = eat_i ? length_i : length_i - LEN_W'(1);
        self_hit_c = 1'b0;
        for (int unsigned j = 0; j < MAX_LEN; j++) begin
            if (j < 32'(limit) &&
                head_x_i == {1'b0, seg_x_i[COORD_W*j +: COORD_W]} &&
                head_y_i == {1'b0, seg_y_i[COORD_W*j +: COORD_W]}) begin
                self_hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body.sv
// Snake body controller: segment arrays, length, movement, growth and collisions.
module snake_body
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned STEP    = STEP_DEF,
    parameter int unsigned X_MIN   = X_MIN_DEF,
    parameter int unsigned X_MAX   = X_MAX_DEF,
    parameter int unsigned Y_MIN   = Y_MIN_DEF,
    parameter int unsigned Y_MAX   = Y_MAX_DEF,
    parameter int unsigned START_X = START_X_DEF,
    parameter int unsigned START_Y = START_Y_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       tick,
    input  logic [1:0]                 dir,
    input  logic [COORD_W-1:0]         apple_x,
    input  logic [COORD_W-1:0]         apple_y,
    output logic [MAX_LEN*COORD_W-1:0] block_x,
    output logic [MAX_LEN*COORD_W-1:0] block_y,
    output logic [LEN_W-1:0]           snake_length,
    output logic                       ate,
    output logic                       game_over
);

    localparam logic [MAX_LEN*COORD_W-1:0] INIT_X = {{(MAX_LEN-1){PARK}}, COORD_W'(START_X)};
    localparam logic [MAX_LEN*COORD_W-1:0] INIT_Y = {{(MAX_LEN-1){PARK}}, COORD_W'(START_Y)};

    state_e                     state_q, state_d;
    dir_e                       dir_q, dir_d;
    logic [MAX_LEN*COORD_W-1:0] seg_x_q, seg_x_d, seg_y_q, seg_y_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic                       ate_q, ate_d, game_over_q, game_over_d;

    logic [HEAD_W-1:0]          next_x, next_y;
    logic                       wall_hit, eat, self_hit;

    assign block_x      = seg_x_q;
    assign block_y      = seg_y_q;
    assign snake_length = len_q;
    assign ate          = ate_q;
    assign game_over    = game_over_q;

    // Candidate head one step along the current direction, 11 bits to expose underflow.
    always_comb begin
        next_x = {1'b0, seg_x_q[COORD_W-1:0]};
        next_y = {1'b0, seg_y_q[COORD_W-1:0]};
        unique case (dir_q)
            DIR_UP:    next_y = next_y - HEAD_W'(STEP);
            DIR_RIGHT: next_x = next_x + HEAD_W'(STEP);
            DIR_DOWN:  next_y = next_y + HEAD_W'(STEP);
            DIR_LEFT:  next_x = next_x - HEAD_W'(STEP);
        endcase
        wall_hit = next_x < HEAD_W'(X_MIN) || next_x > HEAD_W'(X_MAX) ||
                   next_y < HEAD_W'(Y_MIN) || next_y > HEAD_W'(Y_MAX);
        eat      = next_x == {1'b0, apple_x} && next_y == {1'b0, apple_y};
    end

    snake_hit_detect #(.MAX_LEN(MAX_LEN)) u_hit (
        .head_x_i   (next_x),
        .head_y_i   (next_y),
        .seg_x_i    (seg_x_q),
        .seg_y_i    (seg_y_q),
        .length_i   (len_q),
        .eat_i      (eat),
        .self_hit_c (self_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start always wins over tick outside RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (tick && (wall_hit || self_hit)) state_d = ST_DEAD;
            default: if (start) state_d = ST_RUN;
        endcase
    end

    // Datapath next values: reinitialise, steer, and shift/grow on a safe tick.
    always_comb begin
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_q;
        dir_d   = dir_q;
        ate_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!is_reverse(dir_e'(dir), dir_q)) dir_d = dir_e'(dir);
                if (tick && !wall_hit && !self_hit) begin
                    if (eat && len_q != LEN_W'(MAX_LEN)) len_d = len_q + LEN_W'(1);
                    ate_d = eat;
                    seg_x_d[COORD_W-1:0] = next_x[COORD_W-1:0];
                    seg_y_d[COORD_W-1:0] = next_y[COORD_W-1:0];
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        if (i >= 32'(len_d)) begin
                            seg_x_d[COORD_W*i +: COORD_W] = PARK;
                            seg_y_d[COORD_W*i +: COORD_W] = PARK;
                        end else begin
                            seg_x_d[COORD_W*i +: COORD_W] = seg_x_q[COORD_W*(i-1) +: COORD_W];
                            seg_y_d[COORD_W*i +: COORD_W] = seg_y_q[COORD_W*(i-1) +: COORD_W];
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    seg_x_d = INIT_X;
                    seg_y_d = INIT_Y;
                    len_d   = LEN_W'(1);
                    dir_d   = DIR_RIGHT;
                end
            end
        endcase
        game_over_d = (state_d == ST_DEAD);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_x_q     <= INIT_X;
            seg_y_q     <= INIT_Y;
            len_q       <= LEN_W'(1);
            dir_q       <= DIR_RIGHT;
            ate_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            ate_q       <= ate_d;
            game_over_q <= game_over_d;
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed scenarios plus random play against a queue-based model.
module tb_snake_body;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         tick = 1'b0;
    logic [1:0]   dir = 2'd1;
    logic [9:0]   apple_x = 10'd600;
    logic [9:0]   apple_y = 10'd41;
    logic [199:0] block_x, block_y;
    logic [4:0]   snake_length;
    logic         ate, game_over;

    int total = 0;
    int bad = 0;

    // Model: snake as a queue of points, head at index 0.
    int qx[$];
    int qy[$];
    int mdir;
    int mstate;   // 0 idle, 1 running, 2 dead
    bit mate;

    always #5 clk = ~clk;

    snake_body dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .dir(dir),
        .apple_x(apple_x), .apple_y(apple_y), .block_x(block_x), .block_y(block_y),
        .snake_length(snake_length), .ate(ate), .game_over(game_over)
    );

    task automatic model_init();
        qx = {450};
        qy = {281};
        mdir = 1;
    endtask

    task automatic model_reset();
        model_init();
        mstate = 0;
        mate = 1'b0;
    endtask

    // One clock edge of the game rules, using the inputs present at that edge.
    task automatic model_edge();
        int nx, ny, n;
        bit wall, eat, hit;
        mate = 1'b0;
        if (mstate != 1) begin
            if (start) begin
                model_init();
                mstate = 1;
            end
        end else begin
            if (tick) begin
                nx = qx[0] + ((mdir == 1) ? 10 : (mdir == 3) ? -10 : 0);
                ny = qy[0] + ((mdir == 2) ? 10 : (mdir == 0) ? -10 : 0);
                wall = nx < 150 || nx > 779 || ny < 41 || ny > 510;
                eat = (nx == int'(apple_x)) && (ny == int'(apple_y));
                n = eat ? qx.size() : qx.size() - 1;
                hit = 1'b0;
                for (int k = 0; k < n; k++) if (qx[k] == nx && qy[k] == ny) hit = 1'b1;
                if (wall || hit) begin
                    mstate = 2;
                end else begin
                    qx.push_front(nx);
                    qy.push_front(ny);
                    if (!eat || qx.size() > 20) begin
                        void'(qx.pop_back());
                        void'(qy.pop_back());
                    end
                    mate = eat;
                end
            end
            if (((int'(dir) + 2) % 4) != mdir) mdir = int'(dir);
        end
    endtask

    task automatic check(input string tag);
        logic [199:0] ex, ey;
        for (int i = 0; i < 20; i++) begin
            ex[10*i +: 10] = (i < qx.size()) ? 10'(qx[i]) : 10'h3FF;
            ey[10*i +: 10] = (i < qy.size()) ? 10'(qy[i]) : 10'h3FF;
        end
        total += 5;
        assert (block_x === ex) else begin bad++; $error("FAIL %s block_x got %h exp %h", tag, block_x, ex); end
        assert (block_y === ey) else begin bad++; $error("FAIL %s block_y got %h exp %h", tag, block_y, ey); end
        assert (snake_length === 5'(qx.size())) else begin bad++; $error("FAIL %s length got %0d exp %0d", tag, snake_length, qx.size()); end
        assert (ate === mate) else begin bad++; $error("FAIL %s ate got %b exp %b", tag, ate, mate); end
        assert (game_over === (mstate == 2)) else begin bad++; $error("FAIL %s game_over got %b exp %b", tag, game_over, mstate == 2); end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin bad++; $error("FAIL %s got %0d exp %0d", tag, got, exp); end
    endtask

    // Drive inputs (called at negedge), advance one clock, check after the edge.
    task automatic step(input string tag, input logic s, input logic t, input int d,
                        input int ax, input int ay);
        start = s;
        tick = t;
        dir = 2'(d);
        apple_x = 10'(ax);
        apple_y = 10'(ay);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        int hx, hy, r, d, ax, ay;
        bit park_seen;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        check_val("rst_x0", int'(block_x[9:0]), 450);
        check_val("rst_y0", int'(block_y[9:0]), 281);
        check_val("rst_x19", int'(block_x[199:190]), 1023);
        rst_n = 1'b1;
        @(negedge clk);
        step("idle_tick", 0, 1, 1, 600, 41);

        // Move and eat.
        step("start", 1, 0, 1, 600, 41);
        step("move", 0, 1, 1, 600, 41);
        check_val("move_x", int'(block_x[9:0]), 460);
        step("eat", 0, 1, 1, 470, 281);
        check_val("eat_len", int'(snake_length), 2);
        check_val("eat_x1", int'(block_x[19:10]), 460);
        step("eat_after", 0, 0, 1, 600, 41);

        // Reverse request dropped, then turn up.
        step("rev_dir", 0, 0, 3, 600, 41);
        step("rev_tick", 0, 1, 3, 600, 41);
        check_val("rev_x", int'(block_x[9:0]), 480);
        step("up_dir", 0, 0, 0, 600, 41);
        step("up_tick", 0, 1, 0, 600, 41);
        check_val("up_y", int'(block_y[9:0]), 271);

        // Steer back to y=281 and run into the right wall.
        step("r_dir", 0, 0, 1, 600, 41);
        step("r_tick", 0, 1, 1, 600, 41);
        step("d_dir", 0, 0, 2, 600, 41);
        step("d_tick", 0, 1, 2, 600, 41);
        step("r2_dir", 0, 0, 1, 600, 41);
        for (int i = 0; i < 28; i++) step("to_wall", 0, 1, 1, 600, 41);
        check_val("wall_pre_x", int'(block_x[9:0]), 770);
        step("wall", 0, 1, 1, 600, 41);
        check_val("wall_go", int'(game_over), 1);
        check_val("wall_x", int'(block_x[9:0]), 770);
        step("dead_tick", 0, 1, 1, 600, 41);
        step("restart", 1, 1, 1, 600, 41);
        check_val("restart_go", int'(game_over), 0);

        // Grow to five, then curl into the body.
        for (int i = 1; i <= 4; i++) step("grow5", 0, 1, 1, 450 + 10 * i, 281);
        check_val("len5", int'(snake_length), 5);
        step("s_up", 0, 0, 0, 600, 41);
        step("s_up_t", 0, 1, 0, 600, 41);
        step("s_left", 0, 0, 3, 600, 41);
        step("s_left_t", 0, 1, 3, 600, 41);
        step("s_down", 0, 0, 2, 600, 41);
        step("s_down_t", 0, 1, 2, 600, 41);
        check_val("self_go", int'(game_over), 1);

        // Grow to capacity and eat once more.
        step("restart2", 1, 0, 1, 600, 41);
        for (int i = 1; i <= 20; i++) step("grow20", 0, 1, 1, 450 + 10 * i, 281);
        check_val("sat_len", int'(snake_length), 20);
        check_val("sat_ate", int'(ate), 1);
        park_seen = 1'b0;
        for (int i = 0; i < 20; i++) if (block_x[10*i +: 10] == 10'h3FF) park_seen = 1'b1;
        check_val("sat_nopark", int'(park_seen), 0);

        // Asynchronous reset in the middle of a tick cycle.
        tick = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick = 1'b0;

        // Random play.
        for (int n = 0; n < 3000; n++) begin
            d = int'(dir);
            if ($urandom_range(3) == 0) d = int'($urandom_range(3));
            ax = int'($urandom_range(1023));
            ay = int'($urandom_range(1023));
            if ($urandom_range(2) == 0 && qx.size() > 0) begin
                r = int'($urandom_range(3));
                hx = qx[0] + ((r == 1) ? 10 : (r == 3) ? -10 : 0);
                hy = qy[0] + ((r == 2) ? 10 : (r == 0) ? -10 : 0);
                ax = hx;
                ay = hy;
            end
            step("rand", (mstate != 1) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0),
                 $urandom_range(1) == 1, d, ax, ay);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Snake body controller: owns the segment coordinate arrays and the snake length that the apple generator reads, and consumes the apple position it produces. On each movement tick it advances the head one grid step, shifts the body, grows on apple contact, and detects wall and self collisions. It sits between the direction/input logic and both the apple generator and the VGA pixel renderer.

## Interface
- MAX_LEN, 20, segment capacity; fixes array depth
- STEP, 10, grid pitch in pixels
- X_MIN, 150 / X_MAX, 779: legal head X range, inclusive
- Y_MIN, 41 / Y_MAX, 510: legal head Y range, inclusive
- START_X, 450 / START_Y, 281: head position after reset or restart
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begins or restarts a game from IDLE or DEAD
- tick  in  1  single-cycle move strobe
- dir  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
- apple_x, apple_y  in  10 each  current apple position
- block_x, block_y  out  MAX_LEN*10 each  flattened segment coordinates; segment i is in bits [10i+9:10i], head is segment 0
- snake_length  out  5  live segment count, 1..MAX_LEN
- ate  out  1  one-cycle pulse on apple consumption
- game_over  out  1  high while in DEAD

## Operation
- FSM states: IDLE, RUN, DEAD. Reset enters IDLE.
- IDLE or DEAD with start=1: reinitialise, then go to RUN next cycle.
  - Reinitialisation: segment 0 = (START_X, START_Y); segments 1..MAX_LEN-1 = PARK (10'h3FF on both axes); length 1; current direction right.
- RUN, dir update: dir is latched into the current direction every cycle unless it is the exact reverse of the current direction. Reverse requests are dropped.
- RUN, on tick:
  - Next head = segment 0 ± STEP along the current direction. Compute it in 11 bits so underflow is visible.
  - Wall hit: next head X outside [X_MIN, X_MAX] or Y outside [Y_MIN, Y_MAX]. Go to DEAD with no position update.
  - Eat: next head equals (apple_x, apple_y).
  - Self hit: next head equals a live segment j. When not eating, j ranges over 0..length-2, because the tail vacates. When eating, j ranges over 0..length-1. Go to DEAD with no position update.
  - Otherwise, shift: seg[i] ← seg[i-1] for i ≥ 1, and seg[0] ← next head.
    - On eat: length ← min(length+1, MAX_LEN) and ate pulses.
    - At MAX_LEN, eating still pulses ate but does not grow.
  - Any segment index ≥ new length is written to PARK. This guarantees that unused slots never match an apple or a collision compare.
- DEAD: all outputs frozen, ticks ignored, game_over=1.
- A tick in IDLE is ignored.

## Timing
- Reset values: segment 0 = (START_X, START_Y), others PARK, snake_length=1, ate=0, game_over=0, state IDLE.
- Move latency: registers update on the clock edge after the tick cycle. ate is asserted in the same cycle as the updated arrays.
- game_over rises on the edge after the colliding tick.
- start and tick in the same cycle from DEAD: start wins, and the tick is ignored.
- Wall and self hit in the same tick: DEAD, with no difference in behaviour.
- Reset asserted mid-move: asynchronous clear to reset values; any pending tick is lost.

## Structure
- snake_pkg holds:
  - direction encoding and the reverse-pair helper;
  - the PARK constant;
  - FSM state enum;
  - default bound constants.
- Sub-module snake_hit_detect: combinational.
  - Inputs: next head, arrays, length, eat.
  - Output: self_hit, produced as an OR of MAX_LEN masked compares.
  - Kept separate so it can be reused by a future second-player block.

## Test plan
- Reset: hold rst_n=0 → segment 0=(450,281), segments 1..19=(1023,1023), length 1, ate 0, game_over 0; a tick in IDLE changes nothing.
- Move: start, apple (600,41), tick with dir=1 → head (460,281), length 1, ate 0.
- Eat: apple (470,281), tick → ate high exactly one cycle, length 2, seg0=(470,281), seg1=(460,281).
- Reverse reject: length 2 heading right, dir=3 plus tick → head (480,281), direction still right. Then dir=0 plus tick → head (480,271).
- Wall: head (770,281) heading right, tick → game_over=1, head stays (770,281). Further ticks are ignored. start → reinitialised state with game_over=0.
- Self hit and saturation:
  - Grow to length 5, then steer up, left, down into the body → DEAD.
  - Separately, grow to 20 and eat again → ate pulses, length stays 20, no slot is PARK.
